// File: rtl/cache_evt_uart_reporter.sv
// Cache-event counter bank: NUM_EVT saturating counters, frozen and dumped as an
// 8N1 UART frame (0xA5, counters MSB-first, 0x5A) on a rising edge of cpu_done.
module cache_evt_uart_reporter #(
    parameter int NUM_EVT      = 8,
    parameter int CNT_W        = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int EDGE_MODE    = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               cpu_done,
    output logic               tx_data,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         state_o
);
    localparam int BPC       = CNT_W / 8;
    localparam int NUM_BYTES = 2 + NUM_EVT * BPC;
    localparam int IDX_W     = $clog2(NUM_BYTES);
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_W     = $clog2(10);
    localparam int CH_W      = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
    localparam int SUB_W     = (BPC > 1) ? $clog2(BPC) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(BPC - 1);
    localparam logic [BIT_W-1:0]  BIT_DATA7 = BIT_W'(8);
    localparam logic [BIT_W-1:0]  BIT_STOP  = BIT_W'(9);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               cpu_done_q, cpu_done_prev_q;
    logic [NUM_EVT-1:0] evt_q;
    logic [CNT_W-1:0]   cnt_q [NUM_EVT];
    logic [7:0]         byte_q, byte_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               clear_cnt;
    logic [NUM_EVT-1:0] inc;
    logic [7:0]         cnt_byte;
    logic [7:0]         load_byte;
    logic               dump_req;

    assign dump_req = cpu_done_q & ~cpu_done_prev_q;
    assign inc      = (EDGE_MODE != 0) ? (evt_i & ~evt_q) : evt_i;

    // ch_q/sub_q walk the frozen bank one byte at a time, most-significant byte first.
    always_comb begin
        cnt_byte = 8'h00;
        for (int i = 0; i < NUM_EVT; i++) begin
            for (int s = 0; s < BPC; s++) begin
                if (ch_q == CH_W'(i) && sub_q == SUB_W'(s)) begin
                    cnt_byte = cnt_q[i][(BPC-1-s)*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        load_byte = cnt_byte;
        if (idx_q == '0) begin
            load_byte = 8'hA5;
        end else if (idx_q == IDX_LAST) begin
            load_byte = 8'h5A;
        end
    end

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        ch_d      = ch_q;
        sub_d     = sub_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        clear_cnt = 1'b0;
        case (state_q)
            ST_COUNT: begin
                tx_d = 1'b1;
                if (dump_req) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    ch_d    = '0;
                    sub_d   = '0;
                end
            end
            ST_LOAD: begin
                byte_d  = load_byte;
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // LOAD takes the last cycle of a non-final stop bit, so leave one cycle early.
                if (bit_q == BIT_STOP && baud_q == BAUD_PRE && idx_q != IDX_LAST) begin
                    state_d = ST_LOAD;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q != '0) begin
                        if (sub_q == SUB_LAST) begin
                            sub_d = '0;
                            ch_d  = ch_q + 1'b1;
                        end else begin
                            sub_d = sub_q + 1'b1;
                        end
                    end
                end else if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_STOP) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = (bit_q == BIT_DATA7) ? 1'b1 : byte_q[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DONE: begin
                tx_d = 1'b1;
                if (!cpu_done) begin
                    state_d   = ST_COUNT;
                    clear_cnt = 1'b1;
                end
            end
            default: begin
                state_d = ST_COUNT;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_COUNT;
            cpu_done_q      <= 1'b0;
            cpu_done_prev_q <= 1'b0;
            evt_q           <= '0;
            byte_q          <= 8'h00;
            baud_q          <= '0;
            bit_q           <= '0;
            idx_q           <= '0;
            ch_q            <= '0;
            sub_q           <= '0;
            tx_q            <= 1'b1;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cpu_done_q      <= cpu_done;
            cpu_done_prev_q <= cpu_done_q;
            evt_q           <= evt_i;
            byte_q          <= byte_d;
            baud_q          <= baud_d;
            bit_q           <= bit_d;
            idx_q           <= idx_d;
            ch_q            <= ch_d;
            sub_q           <= sub_d;
            tx_q            <= tx_d;
            done_q          <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clear_cnt) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (state_q == ST_COUNT) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                if (inc[i] && cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tx_data = tx_q;
    assign busy_o  = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule
